// File: rtl/kgp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : kgp_pkg                                            |
// | Description : Shared encodings for the KGP-RISC immediate path:  |
// |               extension mode codes and skid-buffer states.       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package kgp_pkg;

  // Extension mode encodings carried on in_mode
  localparam logic [1:0] EXT_ZEXT     = 2'b00;
  localparam logic [1:0] EXT_SEXT     = 2'b01;
  localparam logic [1:0] EXT_SEXT_SHL = 2'b10;
  localparam logic [1:0] EXT_UPPER    = 2'b11;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_t;

endpackage
`default_nettype wire

// File: rtl/imm_extend_pipe_ext_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : ext_core                                           |
// | Description : Combinational immediate extender. Produces zero,   |
// |               sign, sign-plus-shift or upper-placed operand.     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module ext_core
  import kgp_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] ext_data
);

  // The shifted sign-extended form must fit in the output word
  generate
    if (OUT_W < IN_W + SHIFT) begin : g_width_check
      $error("ext_core: OUT_W must be >= IN_W + SHIFT");
    end
  endgenerate

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_sext_shl;
  logic [OUT_W-1:0] w_upper;

  // Width casts keep the extensions valid even when OUT_W == IN_W
  assign w_zext     = OUT_W'(in_data);
  assign w_sext     = OUT_W'($signed(in_data));
  assign w_sext_shl = w_sext << SHIFT;
  assign w_upper    = w_zext << (OUT_W - IN_W);

  // Select the extension requested by the mode code
  always_comb begin
    ext_data = w_zext;
    case (in_mode)
      EXT_ZEXT:     ext_data = w_zext;
      EXT_SEXT:     ext_data = w_sext;
      EXT_SEXT_SHL: ext_data = w_sext_shl;
      EXT_UPPER:    ext_data = w_upper;
      default:      ext_data = w_zext;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : imm_extend_pipe                                    |
// | Description : Pipelined immediate-extension stage with a         |
// |               two-entry skid buffer and a transfer counter.      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module imm_extend_pipe
  import kgp_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [15:0]      out_cnt
);

  skid_state_t      r_state;
  logic [OUT_W-1:0] r_main;
  logic [OUT_W-1:0] r_skid;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [15:0]      r_cnt;

  logic [OUT_W-1:0] w_ext;
  logic             w_accept;
  logic             w_drain;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_ext_core (
    .in_data  (in_data),
    .in_mode  (in_mode),
    .ext_data (w_ext)
  );

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_out_valid & out_ready;

  // Skid-buffer FSM: in_ready/out_valid are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main      <= w_ext;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && out_ready) begin
            r_main <= w_ext;
          end else if (w_accept) begin
            // Downstream stalled: park the new word so nothing is dropped
            r_skid     <= w_ext;
            r_in_ready <= 1'b0;
            r_state    <= S_TWO;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_ready) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= S_ONE;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Count completed output handshakes, wrapping naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_drain) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign out_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_imm_extend_pipe                                 |
// | Description : Self-checking bench for imm_extend_pipe.           |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_cnt;

  logic        in_valid12;
  logic        in_ready12;
  logic [11:0] in_data12;
  logic [1:0]  in_mode12;
  logic        out_valid12;
  logic        out_ready12;
  logic [31:0] out_data12;
  logic [15:0] out_cnt12;

  int checks;
  int errors;
  int exp_cnt;
  int sent;
  int recv;
  int cyc;
  logic [31:0] sb[$];

  typedef struct {
    logic [4:0]  data;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [11:0] data;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec12_t;

  vec_t   vecs[8];
  vec12_t vecs12[4];

  imm_extend_pipe #(.IN_W(5), .OUT_W(32), .SHIFT(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(32), .SHIFT(1)) u_dut12 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid12),
    .in_ready  (in_ready12),
    .in_data   (in_data12),
    .in_mode   (in_mode12),
    .out_valid (out_valid12),
    .out_ready (out_ready12),
    .out_data  (out_data12),
    .out_cnt   (out_cnt12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Independent model: sign extension done arithmetically (value - 32)
  function automatic logic [31:0] ref_ext(input logic [4:0] d, input logic [1:0] m);
    logic [31:0] z;
    logic [31:0] s;
    z = {27'd0, d};
    s = d[4] ? (z - 32'd32) : z;
    case (m)
      2'b00:   return z;
      2'b01:   return s;
      2'b10:   return s * 32'd4;
      default: return {d, 27'd0};
    endcase
  endfunction

  initial begin
    checks = 0; errors = 0; exp_cnt = 0;

    vecs[0] = '{5'b10110, 2'b00, 32'h0000_0016};
    vecs[1] = '{5'b10110, 2'b01, 32'hFFFF_FFF6};
    vecs[2] = '{5'b10110, 2'b10, 32'hFFFF_FFD8};
    vecs[3] = '{5'b10110, 2'b11, 32'hB000_0000};
    vecs[4] = '{5'h0F,    2'b01, 32'h0000_000F};
    vecs[5] = '{5'h10,    2'b10, 32'hFFFF_FFC0};
    vecs[6] = '{5'h1F,    2'b11, 32'hF800_0000};
    vecs[7] = '{5'h01,    2'b10, 32'h0000_0004};

    vecs12[0] = '{12'h800, 2'b10, 32'hFFFF_F000};
    vecs12[1] = '{12'h7FF, 2'b00, 32'h0000_07FF};
    vecs12[2] = '{12'h7FF, 2'b11, 32'h7FF0_0000};
    vecs12[3] = '{12'hABC, 2'b01, 32'hFFFF_FABC};

    // Reset with in_valid asserted
    rst_n = 1'b0; in_valid = 1'b1; in_data = 5'h16; in_mode = 2'b01; out_ready = 1'b1;
    in_valid12 = 1'b0; in_data12 = '0; in_mode12 = '0; out_ready12 = 1'b1;
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_cnt", {16'd0, out_cnt}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    check("post_rst_idle", {31'd0, out_valid}, 32'd0);

    // Streaming table at one transfer per cycle
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = vecs[i].data; in_mode = vecs[i].mode;
      tick();
      check($sformatf("stream_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("stream_data_%0d", i), out_data, vecs[i].exp);
      check($sformatf("stream_cnt_%0d", i), {16'd0, out_cnt}, 32'(i));
    end
    in_valid = 1'b0; in_mode = 2'b11;
    tick();
    exp_cnt = 8;
    check("stream_drained", {31'd0, out_valid}, 32'd0);
    check("stream_cnt", {16'd0, out_cnt}, 32'(exp_cnt));

    // Back-pressure into the skid entry
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 5'h01; in_mode = 2'b00;
    tick();
    check("bp_a_data", out_data, 32'h0000_0001);
    check("bp_a_ready", {31'd0, in_ready}, 32'd1);
    in_data = 5'h1F; in_mode = 2'b01;
    tick();
    check("bp_b_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_data", out_data, 32'h0000_0001);
    in_valid = 1'b0; in_mode = 2'b11;
    tick();
    check("bp_hold_data2", out_data, 32'h0000_0001);
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_b_data", out_data, 32'hFFFF_FFFF);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    exp_cnt += 2;
    check("bp_empty", {31'd0, out_valid}, 32'd0);
    check("bp_cnt", {16'd0, out_cnt}, 32'(exp_cnt));

    // Random handshakes against a scoreboard
    sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      if (!(in_valid && !in_ready)) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_data  = 5'($urandom);
          in_mode  = 2'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL rand_dup actual=unexpected_output required=no_output");
        end else begin
          check("rand_data", out_data, sb.pop_front());
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_ext(in_data, in_mode));
        sent++;
      end
      tick();
      cyc++;
    end
    if (cyc >= 20000) begin
      checks++; errors++;
      $display("FAIL rand_timeout actual=%0d required=1000", recv);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    exp_cnt += 1000;
    check("rand_sb_empty", 32'(sb.size()), 32'd0);
    check("rand_cnt", {16'd0, out_cnt}, 32'(exp_cnt % 65536));
    check("rand_idle", {31'd0, out_valid}, 32'd0);

    // Wide-input instance: IN_W=12, SHIFT=1
    for (int i = 0; i < 4; i++) begin
      in_valid12 = 1'b1; in_data12 = vecs12[i].data; in_mode12 = vecs12[i].mode;
      tick();
      check($sformatf("w12_data_%0d", i), out_data12, vecs12[i].exp);
    end
    in_valid12 = 1'b0;
    tick();
    check("w12_cnt", {16'd0, out_cnt12}, 32'd4);

    // Asynchronous reset while both entries are held
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 5'h03; in_mode = 2'b00;
    tick();
    in_data = 5'h05;
    tick();
    in_valid = 1'b0;
    check("two_ready", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    check("arst_cnt", {16'd0, out_cnt}, 32'd0);
    check("arst_data", out_data, 32'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick(); tick();
    check("arst_no_stale", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_data = 5'h1A; in_mode = 2'b01;
    tick();
    in_valid = 1'b0;
    check("arst_new_data", out_data, 32'hFFFF_FFFA);
    tick();
    check("arst_new_cnt", {16'd0, out_cnt}, 32'd1);
    check("arst_new_idle", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
